// File: rtl/cache_mem_arbiter_pkg.sv
// Shared CPU types for the cache pair, the memory arbiter and the RAM model.
package cache_mem_arbiter_pkg;

    typedef logic [31:0] word_t;

    // RAM port status as reported by the RAM model / bus interface.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Memory arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFETCH = 2'd1,
        DBEAT0 = 2'd2,
        DBEAT1 = 2'd3
    } arbstate_t;

    // Which requester received the most recent grant.
    typedef enum logic {
        GrantIcache = 1'b0,
        GrantDcache = 1'b1
    } grant_t;

    // Icache address view: one word per line.
    typedef struct packed {
        logic [25:0] tag;
        logic [3:0]  idx;
        logic [1:0]  bytoff;
    } icachef_t;

    // Dcache address view: two-word blocks.
    typedef struct packed {
        logic [25:0] tag;
        logic [2:0]  idx;
        logic        blkoff;
        logic [1:0]  bytoff;
    } dcachef_t;

endpackage

// File: rtl/cache_mem_arbiter_beat_timer.sv
// Per-beat timeout counter for the memory arbiter. TIMEOUT == 0 builds no counter.
module cache_mem_arbiter_beat_timer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    if (TIMEOUT == 0) begin : g_off
        logic unused_timer;
        assign unused_timer = ^{CLK, nRST, clear, enable};
        assign expired = 1'b0;
    end else begin : g_on
        localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
        localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

        logic [CntW-1:0] count_q;

        // Count waiting cycles of the current beat; clear has priority.
        always_ff @(posedge CLK) begin
            if (!nRST || clear) begin
                count_q <= '0;
            end else if (enable) begin
                count_q <= count_q + CntW'(1);
            end
        end

        // This waiting cycle would bring the count up to TIMEOUT.
        assign expired = enable && (count_q == CntLast);
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Single-port RAM arbiter between the icache (word fills) and the dcache (two-word
// block fills/writebacks). Optional macro MEMARB_RR_EN selects round-robin on ties;
// otherwise the dcache always wins ties.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  word_t       iaddr,
    output logic        iwait,
    output word_t       iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  word_t       daddr,
    input  word_t [1:0] dstore,
    output logic        dwait,
    output word_t [1:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output word_t       ramaddr,
    output word_t       ramstore,
    input  word_t       ramload,
    input  ramstate_t   ramstate,
    output logic        merr
);

    arbstate_t state_q;
    word_t     dload0_q;
    icachef_t  iaddr_f;
    dcachef_t  daddr_f;
    logic      dreq, active, access, withdrawn, abort, expired;
    logic      timer_clear, timer_en, pick_d, icomplete, dcomplete;
    logic      unused_addr;

`ifdef MEMARB_RR_EN
    grant_t    last_grant_q;
`endif

    assign iaddr_f     = iaddr;
    assign daddr_f     = daddr;
    assign unused_addr = ^{iaddr_f.bytoff, daddr_f.blkoff, daddr_f.bytoff};
    assign dreq        = dREN | dWEN;

    // Beat status: completion, withdrawal and abort conditions of the current state.
    always_comb begin
        active    = (state_q != IDLE);
        access    = (ramstate == ACCESS);
        withdrawn = ((state_q == IFETCH) && !iREN) ||
                    ((state_q == DBEAT0 || state_q == DBEAT1) && !dreq);
        abort     = active && !withdrawn && ((ramstate == ERROR) || expired);
        timer_en  = active && !access;
        // Leaving or re-entering a beat restarts its count.
        timer_clear = !active || access || withdrawn || abort;
    end

    // Tie resolution between simultaneous requests in IDLE.
    always_comb begin
`ifdef MEMARB_RR_EN
        pick_d = dreq && (!iREN || (last_grant_q == GrantIcache));
`else
        pick_d = dreq;
`endif
    end

    cache_mem_arbiter_beat_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_beat_timer (
        .CLK     (CLK),
        .nRST    (nRST),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (expired)
    );

    // Arbiter FSM with the latched low fill word and grant history.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= IDLE;
            dload0_q <= '0;
`ifdef MEMARB_RR_EN
            last_grant_q <= GrantIcache;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_d) begin
                        state_q <= DBEAT0;
`ifdef MEMARB_RR_EN
                        last_grant_q <= GrantDcache;
`endif
                    end else if (iREN) begin
                        state_q <= IFETCH;
`ifdef MEMARB_RR_EN
                        last_grant_q <= GrantIcache;
`endif
                    end
                end
                IFETCH: begin
                    if (withdrawn || abort || access) state_q <= IDLE;
                end
                DBEAT0: begin
                    if (withdrawn || abort) begin
                        state_q <= IDLE;
                    end else if (access) begin
                        state_q <= DBEAT1;
                        if (!dWEN) dload0_q <= ramload;
                    end
                end
                DBEAT1: begin
                    if (withdrawn || abort || access) state_q <= IDLE;
                end
            endcase
        end
    end

    // RAM strobes and requester responses decoded from state.
    always_comb begin
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;
        iload     = '0;
        dload     = {32'h0, dload0_q};
        icomplete = 1'b0;
        dcomplete = 1'b0;
        unique case (state_q)
            IDLE: ;
            IFETCH: begin
                ramREN    = 1'b1;
                ramaddr   = {iaddr_f.tag, iaddr_f.idx, 2'b00};
                iload     = ramload;
                icomplete = access || abort;
            end
            DBEAT0: begin
                ramaddr = {daddr_f.tag, daddr_f.idx, 3'b000};
                // Illegal dREN+dWEN is treated as a write.
                if (dWEN) begin
                    ramWEN   = 1'b1;
                    ramstore = dstore[0];
                end else begin
                    ramREN = 1'b1;
                end
                dcomplete = abort;
            end
            DBEAT1: begin
                ramaddr = {daddr_f.tag, daddr_f.idx, 3'b100};
                if (dWEN) begin
                    ramWEN   = 1'b1;
                    ramstore = dstore[1];
                end else begin
                    ramREN = 1'b1;
                end
                dload[1]  = ramload;
                dcomplete = access || abort;
            end
        endcase
        iwait = iREN && !icomplete;
        dwait = dreq && !dcomplete;
        // A burst dropped by reset is not an error.
        merr  = abort && nRST;
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter (built with TIMEOUT = 4).
module tb_cache_mem_arbiter;
    import cache_mem_arbiter_pkg::*;

    logic        CLK;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    word_t       iaddr, daddr, iload, ramaddr, ramstore, ramload;
    word_t [1:0] dstore, dload;
    logic        iwait, dwait, ramREN, ramWEN, merr;
    ramstate_t   ramstate;

    int n_checks = 0;
    int n_fail   = 0;

    cache_mem_arbiter #(
        .TIMEOUT (4)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .merr     (merr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One cycle of stimulus and the outputs expected in that same cycle.
    typedef struct {
        logic [3:0] req;    // {nRST, iREN, dREN, dWEN}
        word_t      ia, da, s0, s1;
        ramstate_t  rs;
        word_t      rl;
        logic [4:0] flags;  // {iwait, dwait, ramREN, ramWEN, merr}
        word_t      ea, es, eil, ed0, ed1;
    } vec_t;

    vec_t  vecs[$];
    word_t ctx_ia, ctx_da, ctx_s0, ctx_s1;

    function automatic void add(logic [3:0] req, ramstate_t rs, word_t rl, logic [4:0] flags,
                                word_t ea, word_t es, word_t eil, word_t ed0, word_t ed1);
        vec_t v;
        v.req = req; v.ia = ctx_ia; v.da = ctx_da; v.s0 = ctx_s0; v.s1 = ctx_s1;
        v.rs = rs; v.rl = rl; v.flags = flags;
        v.ea = ea; v.es = es; v.eil = eil; v.ed0 = ed0; v.ed1 = ed1;
        vecs.push_back(v);
    endfunction

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_d;
        logic       got_d;

        nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
        ctx_ia = '0; ctx_da = '0; ctx_s0 = '0; ctx_s1 = '0;

        // Reset state.
        add(4'b0000, FREE,   0,            5'b00000, 0,      0,      0,            0,      0);
        // Icache fill, ACCESS on the 2nd strobe cycle.
        ctx_ia = 32'h0000_0107;
        add(4'b1100, FREE,   0,            5'b10000, 0,      0,      0,            0,      0);
        add(4'b1100, BUSY,   0,            5'b10100, 32'h104, 0,     0,            0,      0);
        add(4'b1100, ACCESS, 32'hDEADBEEF, 5'b00100, 32'h104, 0,     32'hDEADBEEF, 0,      0);
        add(4'b1000, FREE,   0,            5'b00000, 0,      0,      0,            0,      0);
        // Dcache fill.
        ctx_da = 32'h0000_0A0C;
        add(4'b1010, FREE,   0,            5'b01000, 0,      0,      0,            0,      0);
        add(4'b1010, ACCESS, 32'h11,       5'b01100, 32'hA08, 0,     0,            0,      0);
        add(4'b1010, ACCESS, 32'h22,       5'b00100, 32'hA0C, 0,     0,            32'h11, 32'h22);
        add(4'b1000, FREE,   0,            5'b00000, 0,      0,      0,            32'h11, 0);
        // Dcache writeback; read data on a write beat must not be latched.
        ctx_s0 = 32'hAA; ctx_s1 = 32'hBB;
        add(4'b1001, FREE,   0,            5'b01000, 0,      0,      0,            32'h11, 0);
        add(4'b1001, BUSY,   0,            5'b01010, 32'hA08, 32'hAA, 0,           32'h11, 0);
        add(4'b1001, ACCESS, 32'h55,       5'b01010, 32'hA08, 32'hAA, 0,           32'h11, 0);
        add(4'b1001, ACCESS, 0,            5'b00010, 32'hA0C, 32'hBB, 0,           32'h11, 0);
        add(4'b1000, FREE,   0,            5'b00000, 0,      0,      0,            32'h11, 0);
        // ERROR on beat 0, one IDLE cycle, re-grant then withdrawal.
        ctx_da = 32'h0000_0040;
        add(4'b1010, FREE,   0,            5'b01000, 0,      0,      0,            32'h11, 0);
        add(4'b1010, ERROR,  0,            5'b00101, 32'h40, 0,      0,            32'h11, 0);
        add(4'b1010, FREE,   0,            5'b01000, 0,      0,      0,            32'h11, 0);
        add(4'b1000, FREE,   0,            5'b00100, 32'h40, 0,      0,            32'h11, 0);
        add(4'b1000, FREE,   0,            5'b00000, 0,      0,      0,            32'h11, 0);
        // Timeout: RAM stuck BUSY, abort on the 4th strobe cycle.
        ctx_ia = 32'h0000_0050;
        add(4'b1100, FREE,   0,            5'b10000, 0,      0,      0,            32'h11, 0);
        add(4'b1100, BUSY,   0,            5'b10100, 32'h50, 0,      0,            32'h11, 0);
        add(4'b1100, BUSY,   0,            5'b10100, 32'h50, 0,      0,            32'h11, 0);
        add(4'b1100, BUSY,   0,            5'b10100, 32'h50, 0,      0,            32'h11, 0);
        add(4'b1100, BUSY,   0,            5'b00101, 32'h50, 0,      0,            32'h11, 0);
        add(4'b1000, FREE,   0,            5'b00000, 0,      0,      0,            32'h11, 0);
        // Reset asserted during DBEAT1.
        ctx_da = 32'h0000_0060;
        add(4'b1010, FREE,   0,            5'b01000, 0,      0,      0,            32'h11, 0);
        add(4'b1010, ACCESS, 32'h77,       5'b01100, 32'h60, 0,      0,            32'h11, 0);
        add(4'b0010, BUSY,   0,            5'b01100, 32'h64, 0,      0,            32'h77, 0);
        add(4'b1000, FREE,   0,            5'b00000, 0,      0,      0,            0,      0);

        repeat (2) @(posedge CLK);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLK);
            {nRST, iREN, dREN, dWEN} = vecs[i].req;
            iaddr = vecs[i].ia; daddr = vecs[i].da;
            dstore = {vecs[i].s1, vecs[i].s0};
            ramstate = vecs[i].rs; ramload = vecs[i].rl;
            #1;
            chk($sformatf("v%0d_iwait", i),    32'(iwait),  32'(vecs[i].flags[4]));
            chk($sformatf("v%0d_dwait", i),    32'(dwait),  32'(vecs[i].flags[3]));
            chk($sformatf("v%0d_ramREN", i),   32'(ramREN), 32'(vecs[i].flags[2]));
            chk($sformatf("v%0d_ramWEN", i),   32'(ramWEN), 32'(vecs[i].flags[1]));
            chk($sformatf("v%0d_merr", i),     32'(merr),   32'(vecs[i].flags[0]));
            chk($sformatf("v%0d_ramaddr", i),  ramaddr,     vecs[i].ea);
            chk($sformatf("v%0d_ramstore", i), ramstore,    vecs[i].es);
            chk($sformatf("v%0d_iload", i),    iload,       vecs[i].eil);
            chk($sformatf("v%0d_dload0", i),   dload[0],    vecs[i].ed0);
            chk($sformatf("v%0d_dload1", i),   dload[1],    vecs[i].ed1);
        end

        // Simultaneous requests held for four transactions; bit k = 1 means dcache grant.
`ifdef MEMARB_RR_EN
        exp_d = 4'b0101;
`else
        exp_d = 4'b1111;
`endif
        @(negedge CLK);
        iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
        iaddr = 32'h200; daddr = 32'h300; ramstate = ACCESS; ramload = '0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("tie%0d_idle_strobes", k), 32'({ramREN, ramWEN}), 32'h0);
            @(negedge CLK); #1;
            got_d = (ramaddr == 32'h300);
            chk($sformatf("tie%0d_grant_dcache", k), 32'(got_d), 32'(exp_d[k]));
            if (got_d) begin
                @(negedge CLK); #1;
            end
            @(negedge CLK); #1;
        end
        iREN = 1'b0; dREN = 1'b0; ramstate = FREE;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
